dct_sum_sched: RTL and testbench

Sequencer for the 8-input pipelined DCT adder tree (8 × 14-bit two's-complement products in, 12-bit `dct` out). For one 8×8 block it handshakes input rows from upstream and steps the coefficient select through the eight basis functions per row. It tracks each issued sum through the adder's fixed latency and generates the write enable and transposed address for the result buffer. It sits between the row buffer / coefficient-multiplier stage and the transpose RAM.

---
 rtl/dct_sum_sched_if.sv | 26 ++
 rtl/dct_sum_sched.sv | 161 ++++++++++++++++
 tb/tb_dct_sum_sched.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dct_sum_sched_if.sv
// dct_sum_sched_if: handshake and result-buffer bus of the DCT sum sequencer.
//   master : upstream/host side   (drives start, row_valid)
//   slave  : sequencer side       (drives row_ack, issue, coef_sel, row_idx,
//                                  out_we, out_addr, busy, done)
interface dct_sum_sched_if;
    logic       start;
    logic       row_valid;
    logic       row_ack;
    logic       issue;
    logic [2:0] coef_sel;
    logic [2:0] row_idx;
    logic       out_we;
    logic [5:0] out_addr;
    logic       busy;
    logic       done;

    modport master (
        output start, row_valid,
        input  row_ack, issue, coef_sel, row_idx, out_we, out_addr, busy, done
    );

    modport slave (
        input  start, row_valid,
        output row_ack, issue, coef_sel, row_idx, out_we, out_addr, busy, done
    );
endinterface

// File: rtl/dct_sum_sched.sv
// dct_sum_sched: sequences one 8x8 block through the pipelined 8-input DCT
// adder tree. Accepts input rows, steps the basis index through 0..7 per row,
// tracks each issued sum through the adder latency and produces the write
// enable and transposed address ({coef,row}) for the result buffer.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : dct_sum_sched_if.slave (start/row_valid in; row_ack, issue,
//          coef_sel, row_idx, out_we, out_addr, busy, done out)
//   LATENCY : issue-to-dct cycles of the adder tree, 1..15
module dct_sum_sched #(
    parameter int unsigned LATENCY = 6
) (
    input  logic            clk,
    input  logic            rst,
    dct_sum_sched_if.slave  bus
);

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned LAST_WR = 63;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ROW,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_coef;
    logic [IDX_W-1:0]   w_coef_nxt;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   w_row_nxt;
    logic [CNT_W-1:0]   r_wr_cnt;

    logic [LATENCY-1:0] r_dl_vld;
    logic [IDX_W-1:0]   r_dl_coef [LATENCY];
    logic [IDX_W-1:0]   r_dl_row  [LATENCY];

    logic               w_issue;
    logic               w_start_acc;
    logic               w_out_we;
    logic               w_done;
    logic               w_pending;

    assign w_issue     = (r_state == S_ISSUE);
    assign w_start_acc = (r_state == S_IDLE) && bus.start;
    assign w_out_we    = r_dl_vld[LATENCY-1];
    assign w_done      = w_out_we && (r_wr_cnt == CNT_W'(LAST_WR));

    // Valid entries still travelling that will surface after this cycle.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            w_pending = w_pending | r_dl_vld[i];
        end
    end

    // State register and row/coefficient counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_coef  <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_coef  <= w_coef_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_coef_nxt  = r_coef;
        w_row_nxt   = r_row;
        case (r_state)
            S_IDLE: begin
                w_coef_nxt = '0;
                w_row_nxt  = '0;
                if (bus.start) begin
                    w_state_nxt = S_WAIT_ROW;
                end
            end
            S_WAIT_ROW: begin
                w_coef_nxt = '0;
                if (bus.row_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // coef wraps to 0 naturally after 7
                w_coef_nxt = r_coef + IDX_W'(1);
                if (r_coef == IDX_W'(7)) begin
                    if (r_row != IDX_W'(7)) begin
                        w_row_nxt   = r_row + IDX_W'(1);
                        w_state_nxt = S_WAIT_ROW;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // leave on the cycle the last in-flight sum is written
                if (!w_pending) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Adder-latency delay line. Payload only advances behind a valid entry,
    // so the last stage keeps the most recent address between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_vld <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_dl_coef[i] <= '0;
                r_dl_row[i]  <= '0;
            end
        end else begin
            r_dl_vld[0] <= w_issue;
            if (w_issue) begin
                r_dl_coef[0] <= r_coef;
                r_dl_row[0]  <= r_row;
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                if (r_dl_vld[i-1]) begin
                    r_dl_coef[i] <= r_dl_coef[i-1];
                    r_dl_row[i]  <= r_dl_row[i-1];
                end
            end
        end
    end

    // Result write counter; restarts with each accepted block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_cnt <= '0;
        end else if (w_start_acc) begin
            r_wr_cnt <= '0;
        end else if (w_out_we) begin
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        end
    end

    assign bus.row_ack  = (r_state == S_WAIT_ROW) && bus.row_valid;
    assign bus.issue    = w_issue;
    assign bus.coef_sel = r_coef;
    assign bus.row_idx  = r_row;
    assign bus.out_we   = w_out_we;
    assign bus.out_addr = {r_dl_coef[LATENCY-1], r_dl_row[LATENCY-1]};
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = w_done;

endmodule

// File: tb/tb_dct_sum_sched.sv
// Directed bench for dct_sum_sched: three instances (LATENCY 6, 1, 15) driven
// with the same start/row_valid/rst stimulus, checked against a cycle table
// and hand-computed per-scenario totals.
module tb_dct_sum_sched;

    logic clk;
    logic rst;
    logic start;
    logic rv;

    dct_sum_sched_if b6 ();
    dct_sum_sched_if b1 ();
    dct_sum_sched_if b15 ();

    assign b6.start      = start;
    assign b6.row_valid  = rv;
    assign b1.start      = start;
    assign b1.row_valid  = rv;
    assign b15.start     = start;
    assign b15.row_valid = rv;

    dct_sum_sched #(.LATENCY(6))  u_l6  (.clk(clk), .rst(rst), .bus(b6.slave));
    dct_sum_sched #(.LATENCY(1))  u_l1  (.clk(clk), .rst(rst), .bus(b1.slave));
    dct_sum_sched #(.LATENCY(15)) u_l15 (.clk(clk), .rst(rst), .bus(b15.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       ack;
        logic       iss;
        logic [2:0] coef;
        logic [2:0] row;
        logic       we;
        logic [5:0] addr;
        logic       done;
        logic       busy;
    } vec_t;

    localparam int NVEC = 13;
    vec_t tbl [NVEC];

    int checks = 0;
    int errors = 0;

    int wr_cnt    [3];
    int first_we  [3];
    int done_cnt  [3];
    int done_at   [3];
    int busy_cnt  [3];
    int iss_cnt   [3];
    int gap_iss   [3];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void clear_stats();
        for (int k = 0; k < 3; k++) begin
            wr_cnt[k]   = 0;
            first_we[k] = -1;
            done_cnt[k] = 0;
            done_at[k]  = -1;
            busy_cnt[k] = 0;
            iss_cnt[k]  = 0;
            gap_iss[k]  = 0;
        end
    endfunction

    // Per-instance monitor; write k of a block lands at coef=k%8, row=k/8.
    function automatic void mon(input int k, input logic we, input logic [5:0] addr,
                                input logic dn, input logic bsy, input logic iss,
                                input int rel);
        logic [5:0] exp_addr;
        if (we) begin
            exp_addr = 6'(((wr_cnt[k] % 8) * 8) + ((wr_cnt[k] % 64) / 8));
            checks++;
            if (addr !== exp_addr) begin
                errors++;
                $display("FAIL addr_order dut%0d write %0d cyc %0d: got %0d expected %0d",
                         k, wr_cnt[k], rel, addr, exp_addr);
            end
            if (first_we[k] < 0) first_we[k] = rel;
            wr_cnt[k]++;
        end
        if (dn) begin
            done_cnt[k]++;
            done_at[k] = rel;
        end
        if (bsy) busy_cnt[k]++;
        if (iss) iss_cnt[k]++;
        if (iss && !rv) gap_iss[k]++;
    endfunction

    function automatic logic is_start(input int id, input int rel);
        case (id)
            2:       return (rel == 0) || (rel == 50);
            3:       return (rel == 0) || (rel == 30) || (rel == 78);
            4:       return (rel == 0) || (rel == 79);
            default: return (rel == 0);
        endcase
    endfunction

    function automatic logic row_v(input int id, input int rel);
        if (id == 1 && ((rel >= 19 && rel <= 21) || (rel >= 49 && rel <= 51))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_scn(input int id, input int ncyc);
        logic [16:0] got;
        logic [16:0] exp;
        logic [5:0]  cr;
        rst = 1'b1; start = 1'b0; rv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        for (int rel = 0; rel < ncyc; rel++) begin
            start = is_start(id, rel);
            rv    = row_v(id, rel);
            rst   = (id == 2) && (rel == 40);
            @(negedge clk);
            mon(0, b6.out_we,  b6.out_addr,  b6.done,  b6.busy,  b6.issue,  rel);
            mon(1, b1.out_we,  b1.out_addr,  b1.done,  b1.busy,  b1.issue,  rel);
            mon(2, b15.out_we, b15.out_addr, b15.done, b15.busy, b15.issue, rel);
            if (id == 0) begin
                for (int i = 0; i < NVEC; i++) begin
                    if (tbl[i].cyc == rel) begin
                        cr  = (tbl[i].iss || tbl[i].ack) ? {b6.coef_sel, b6.row_idx} : 6'd0;
                        got = {b6.row_ack, b6.issue, cr, b6.out_we, b6.out_addr, b6.done, b6.busy};
                        cr  = (tbl[i].iss || tbl[i].ack) ? {tbl[i].coef, tbl[i].row} : 6'd0;
                        exp = {tbl[i].ack, tbl[i].iss, cr, tbl[i].we, tbl[i].addr,
                               tbl[i].done, tbl[i].busy};
                        checks++;
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL tbl[%0d] cyc %0d: got %h expected %h", i, rel, got, exp);
                        end
                    end
                end
            end
            if (id == 1 && rel == 22) chk("gap_ack_row2", int'(b6.row_ack), 1);
            if (id == 1 && rel == 23)
                chk("gap_resume_row2", int'({b6.issue, b6.coef_sel, b6.row_idx}), int'({1'b1, 3'd0, 3'd2}));
            if (id == 2 && rel == 41) begin
                chk("rst_outputs_l6", int'({b6.row_ack, b6.issue, b6.coef_sel, b6.row_idx,
                    b6.out_we, b6.out_addr, b6.done, b6.busy}), 0);
                chk("rst_outputs_l15", int'({b15.row_ack, b15.issue, b15.coef_sel, b15.row_idx,
                    b15.out_we, b15.out_addr, b15.done, b15.busy}), 0);
            end
            if (rst) clear_stats();
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rv = 1'b0;
        //          cyc ack iss coef row we addr done busy
        tbl[0]  = '{0,  0, 0, 3'd0, 3'd0, 0, 6'd0,  0, 0};
        tbl[1]  = '{1,  1, 0, 3'd0, 3'd0, 0, 6'd0,  0, 1};
        tbl[2]  = '{2,  0, 1, 3'd0, 3'd0, 0, 6'd0,  0, 1};
        tbl[3]  = '{8,  0, 1, 3'd6, 3'd0, 1, 6'd0,  0, 1};
        tbl[4]  = '{9,  0, 1, 3'd7, 3'd0, 1, 6'd8,  0, 1};
        tbl[5]  = '{10, 1, 0, 3'd0, 3'd1, 1, 6'd16, 0, 1};
        tbl[6]  = '{16, 0, 1, 3'd5, 3'd1, 0, 6'd56, 0, 1};
        tbl[7]  = '{17, 0, 1, 3'd6, 3'd1, 1, 6'd1,  0, 1};
        tbl[8]  = '{64, 1, 0, 3'd0, 3'd7, 1, 6'd22, 0, 1};
        tbl[9]  = '{72, 0, 1, 3'd7, 3'd7, 1, 6'd15, 0, 1};
        tbl[10] = '{73, 0, 0, 3'd0, 3'd0, 1, 6'd23, 0, 1};
        tbl[11] = '{78, 0, 0, 3'd0, 3'd0, 1, 6'd63, 1, 1};
        tbl[12] = '{79, 0, 0, 3'd0, 3'd0, 0, 6'd63, 0, 0};

        // Single block, row_valid held high; latency sweep alongside.
        run_scn(0, 100);
        chk("s0_writes",     wr_cnt[0],   64);
        chk("s0_first_we",   first_we[0], 8);
        chk("s0_done_at",    done_at[0],  78);
        chk("s0_done_cnt",   done_cnt[0], 1);
        chk("s0_busy_cycles", busy_cnt[0], 78);
        chk("s0_issues",     iss_cnt[0],  64);
        chk("l1_first_we",   first_we[1], 3);
        chk("l1_done_at",    done_at[1],  73);
        chk("l15_first_we",  first_we[2], 17);
        chk("l15_done_at",   done_at[2],  87);
        chk("l15_writes",    wr_cnt[2],   64);

        // Row gaps before rows 2 and 5.
        run_scn(1, 110);
        chk("s1_writes",     wr_cnt[0],   64);
        chk("s1_done_at",    done_at[0],  84);
        chk("s1_done_cnt",   done_cnt[0], 1);
        chk("s1_gap_issue",  gap_iss[0],  0);
        chk("s1_issues",     iss_cnt[0],  64);
        chk("s1_busy_cycles", busy_cnt[0], 84);

        // Reset mid-block, restart at 50.
        run_scn(2, 150);
        chk("s2_first_we",   first_we[0], 58);
        chk("s2_writes",     wr_cnt[0],   64);
        chk("s2_done_at",    done_at[0],  128);
        chk("s2_done_cnt",   done_cnt[0], 1);
        chk("s2_l1_first",   first_we[1], 53);
        chk("s2_l1_done",    done_at[1],  123);
        chk("s2_l15_first",  first_we[2], 67);
        chk("s2_l15_done",   done_at[2],  137);

        // Start pulses while busy are ignored.
        run_scn(3, 110);
        chk("s3_done_cnt",   done_cnt[0], 1);
        chk("s3_done_at",    done_at[0],  78);
        chk("s3_writes",     wr_cnt[0],   64);

        // Start in the cycle after done is accepted.
        run_scn(4, 180);
        chk("s4_done_cnt",   done_cnt[0], 2);
        chk("s4_done_at",    done_at[0],  157);
        chk("s4_writes",     wr_cnt[0],   128);
        chk("s4_l1_done_cnt", done_cnt[1], 2);
        chk("s4_l1_done_at", done_at[1],  152);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
